// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants and state type for the config chain master.
package cfg_pkg;
  localparam int CFG_N_WORDS = 12;
  localparam int CFG_STAGES_PER_DENDRITE = 3;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} cfg_state_t;
endpackage

// File: rtl/fp.sv
// fp: shared fixed-point word type used across the dendrite datapath.
package fp;
  localparam int WORD_LENGTH = 16;
  typedef logic [WORD_LENGTH-1:0] fpType;
endpackage

// File: rtl/config_if.sv
// config_if: parameter shift chain link (shift clock plus data word).
interface config_if;
  logic data_clk;
  fp::fpType data_in;
  modport master(output data_clk, data_in);
  modport slave(input data_clk, data_in);
endinterface

// File: rtl/cfg_clk_gen.sv
// cfg_clk_gen: divides clk into data_clk phases of CLK_DIV cycles with rise/fall strobes.
module cfg_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic data_clk,
  output logic rise,
  output logic fall
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(CLK_DIV - 1);
  // Strobes fire in the last cycle of a phase, so they coincide with the toggling edge.
  assign rise = run && !data_clk && last;
  assign fall = run && data_clk && last;
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
      data_clk <= 1'b0;
    end else if (last) begin
      cnt <= '0;
      data_clk <= !data_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/config_chain_master.sv
// config_chain_master: shifts a host-written parameter image into the config chain.
// Optional CFG_READBACK_EN captures the words returning from the chain tail.
module config_chain_master
  import cfg_pkg::*;
#(
  parameter int N_WORDS = CFG_N_WORDS,
  parameter int CLK_DIV = 2,
  parameter int AW = $clog2(N_WORDS)
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [fp::WORD_LENGTH-1:0] wr_data,
  input  logic start,
  output logic busy,
  output logic done,
  config_if.master cfg_out,
  input  logic [fp::WORD_LENGTH-1:0] cfg_ret,
  input  logic [AW-1:0] rd_addr,
  output logic [fp::WORD_LENGTH-1:0] rd_data
);
  localparam int WL = fp::WORD_LENGTH;
  localparam logic [AW:0] NW = (AW+1)'(N_WORDS);
  cfg_state_t state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic [WL-1:0] data_q, data_d;
  logic done_d, wr_ok, data_clk, rise, fall;
  logic [WL-1:0] image [N_WORDS];
  logic [WL-1:0] top_word;
  assign busy = state != IDLE;
  assign wr_ok = !busy && wr_en && ({1'b0, wr_addr} < NW);
  // Forward a same-cycle write of the first-shifted word so start sees it.
  assign top_word = (wr_ok && wr_addr == AW'(N_WORDS - 1)) ? wr_data : image[N_WORDS-1];
  cfg_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk(clk),
    .reset(reset),
    .run(busy),
    .data_clk(data_clk),
    .rise(rise),
    .fall(fall)
  );
  assign cfg_out.data_clk = data_clk;
  assign cfg_out.data_in = data_q;
  always_comb begin
    state_d = state;
    idx_d = idx;
    data_d = data_q;
    done_d = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_d = LOW;
        idx_d = AW'(N_WORDS - 1);
        data_d = top_word;
      end
    end else if (state == LOW) begin
      state_d = rise ? HIGH : LOW;
    end else if (fall) begin
      if (idx == '0) begin
        state_d = IDLE;
        done_d = 1'b1;
        data_d = '0;
      end else begin
        state_d = LOW;
        idx_d = idx - 1'b1;
        data_d = image[idx - 1'b1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      data_q <= '0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      data_q <= data_d;
      done <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_WORDS; i++) image[i] <= '0;
    end else if (wr_ok) begin
      image[wr_addr] <= wr_data;
    end
  end
`ifdef CFG_READBACK_EN
  logic [WL-1:0] rb [N_WORDS];
  // The tail word is taken on the edge that raises data_clk, before the chain shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_WORDS; i++) rb[i] <= '0;
    end else if (rise) begin
      rb[idx] <= cfg_ret;
    end
  end
  assign rd_data = ({1'b0, rd_addr} < NW) ? rb[rd_addr] : '0;
`else
  logic unused_rb;
  assign unused_rb = ^{cfg_ret, rd_addr};
  assign rd_data = '0;
`endif
endmodule

// File: tb/tb_config_chain_master.sv
// tb_config_chain_master: scoreboard bench with a chain shift-register model on the master output.
module tb_config_chain_master;
  localparam int N = 12;
  localparam int CD = 2;
  localparam int AW = 4;
  localparam int DONE_AT = 2 * CD * N + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] cfg_ret, rd_data;
  logic busy, done;
  config_if cfg();
  config_chain_master dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .busy(busy),
    .done(done),
    .cfg_out(cfg),
    .cfg_ret(cfg_ret),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  logic [15:0] img_m [N];
  logic [15:0] chain [N];
  logic [15:0] a_m [N];
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  logic prev_dclk = 1'b0;
  int passed = 0;
  int total = 0;
  int rise_cnt = 0;
  int done_n, done_cnt, first_rise;
  logic busy1;
  logic [15:0] first_word;
  assign cfg_ret = chain[N-1];

  // Each data_clk rise pops the expected word and shifts the chain model.
  always @(negedge clk) begin
    if (cfg.data_clk && !prev_dclk) begin
      rise_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_rise data_in=%h expected no shift", cfg.data_in);
      end else begin
        mon_e = exp_q.pop_front();
        if (cfg.data_in !== mon_e) $display("FAIL shift_word got=%h exp=%h", cfg.data_in, mon_e);
        else passed++;
      end
      for (int i = N - 1; i > 0; i--) chain[i] = chain[i-1];
      chain[0] = cfg.data_in;
    end
    prev_dclk = cfg.data_clk;
  end

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    img_m[a] = d;
  endtask

  task automatic do_load(input int dist_at, input int rst_at);
    done_n = 0;
    done_cnt = 0;
    first_rise = 0;
    rise_cnt = 0;
    for (int i = N - 1; i >= 0; i--) exp_q.push_back(img_m[i]);
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        wr_en = 1'b0;
        busy1 = busy;
        first_word = cfg.data_in;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (cfg.data_clk === 1'b1 && first_rise == 0) first_rise = n;
      if (n == dist_at) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 4'd3;
        wr_data = 16'hFFFF;
      end
      if (n == dist_at + 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (n == rst_at) reset = 1'b1;
      if (n == rst_at + 1) begin
        total += 3;
        if (cfg.data_clk !== 1'b0) $display("FAIL abort_data_clk got=%b exp=0", cfg.data_clk);
        else passed++;
        if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy);
        else passed++;
        if (cfg.data_in !== 16'h0) $display("FAIL abort_data_in got=%h exp=0000", cfg.data_in);
        else passed++;
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) img_m[i] = '0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 5;
    if (cfg.data_clk !== 1'b0) $display("FAIL reset_data_clk got=%b exp=0", cfg.data_clk);
    else passed++;
    if (cfg.data_in !== 16'h0) $display("FAIL reset_data_in got=%h exp=0000", cfg.data_in);
    else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else passed++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done);
    else passed++;
    if (rd_data !== 16'h0) $display("FAIL reset_rd_data got=%h exp=0000", rd_data);
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      img_m[i] = '0;
      chain[i] = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_load();
    for (int i = 0; i < N; i++) wr(i, 16'h0100 + 16'(i));
    do_load(-5, -5);
    total += 8;
    if (done_n !== DONE_AT) $display("FAIL load_done_time got=%0d exp=%0d", done_n, DONE_AT);
    else passed++;
    if (done_cnt !== 1) $display("FAIL load_done_pulses got=%0d exp=1", done_cnt);
    else passed++;
    if (first_rise !== 3) $display("FAIL load_first_rise got=%0d exp=3", first_rise);
    else passed++;
    if (rise_cnt !== N) $display("FAIL load_rises got=%0d exp=%0d", rise_cnt, N);
    else passed++;
    if (exp_q.size() !== 0) $display("FAIL load_leftover got=%0d exp=0", exp_q.size());
    else passed++;
    if (busy1 !== 1'b1) $display("FAIL load_busy got=%b exp=1", busy1);
    else passed++;
    if (chain[0] !== 16'h0100) $display("FAIL comp0_tau_mem got=%h exp=0100", chain[0]);
    else passed++;
    if (chain[1] !== 16'h0101) $display("FAIL comp0_g_int got=%h exp=0101", chain[1]);
    else passed++;
    for (int i = 0; i < N; i++) begin
      total++;
      if (chain[i] !== img_m[i]) $display("FAIL load_stage%0d got=%h exp=%h", i, chain[i], img_m[i]);
      else passed++;
    end
`ifndef CFG_READBACK_EN
    rd_addr = 4'd5;
    #1;
    total++;
    if (rd_data !== 16'h0) $display("FAIL rd_data_disabled got=%h exp=0000", rd_data);
    else passed++;
`endif
  endtask

  task automatic test_start_ignored();
    do_load(10, -5);
    total += 3;
    if (done_n !== DONE_AT) $display("FAIL busy_start_done got=%0d exp=%0d", done_n, DONE_AT);
    else passed++;
    if (done_cnt !== 1) $display("FAIL busy_start_pulses got=%0d exp=1", done_cnt);
    else passed++;
    if (rise_cnt !== N) $display("FAIL busy_start_rises got=%0d exp=%0d", rise_cnt, N);
    else passed++;
    do_load(-5, -5);
    total++;
    if (chain[3] !== 16'h0103) $display("FAIL busy_write_dropped got=%h exp=0103", chain[3]);
    else passed++;
  endtask

  task automatic test_reset_abort();
    do_load(-5, 20);
    total += 2;
    if (done_cnt !== 0) $display("FAIL abort_done_pulses got=%0d exp=0", done_cnt);
    else passed++;
    if (rise_cnt !== 5) $display("FAIL abort_rises got=%0d exp=5", rise_cnt);
    else passed++;
    do_load(-5, -5);
    total++;
    if (done_n !== DONE_AT) $display("FAIL fresh_done got=%0d exp=%0d", done_n, DONE_AT);
    else passed++;
    for (int i = 0; i < N; i++) begin
      total++;
      if (chain[i] !== 16'h0) $display("FAIL cleared_stage%0d got=%h exp=0000", i, chain[i]);
      else passed++;
    end
  endtask

  task automatic test_same_cycle_fwd();
    wr_en = 1'b1;
    wr_addr = 4'd11;
    wr_data = 16'hBEEF;
    img_m[11] = 16'hBEEF;
    do_load(-5, -5);
    total += 2;
    if (first_word !== 16'hBEEF) $display("FAIL fwd_first_word got=%h exp=BEEF", first_word);
    else passed++;
    if (chain[11] !== 16'hBEEF) $display("FAIL fwd_stage11 got=%h exp=BEEF", chain[11]);
    else passed++;
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback();
    for (int i = 0; i < N; i++) begin
      a_m[i] = 16'($urandom);
      wr(i, a_m[i]);
    end
    do_load(-5, -5);
    for (int i = 0; i < N; i++) wr(i, ~a_m[i]);
    do_load(-5, -5);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      #1;
      total++;
      if (rd_data !== a_m[i]) $display("FAIL readback%0d got=%h exp=%h", i, rd_data, a_m[i]);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_start_ignored();
    test_reset_abort();
    test_same_cycle_fwd();
`ifdef CFG_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
